// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder family.
// Default geometry, chunk-width derivation and a parameter sanity check
// that the adder tops drop into their module bodies.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Bits added per pipeline stage; guards against a zero stage count so the
  // parameter check can report the real problem instead of a divide error.
  function automatic int chunk_width(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction

endpackage

// Elaboration-time check: WIDTH must split evenly into STAGES >= 1 chunks.
`define ADDER_PARAM_CHECK(W, S) \
  if (((S) < 1) || (((W) % (((S) < 1) ? 1 : (S))) != 0)) begin : g_param_check \
    $error("adder: WIDTH must be a multiple of STAGES and STAGES must be >= 1"); \
  end

// File: rtl/full_adder.sv
// One-bit full adder, the leaf cell of every ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple-carry chunk built from full_adder cells.
// Besides the chunk sum and carry out it exposes the carry into the chunk
// MSB, which the last pipeline stage needs for signed overflow.
module rca_chunk #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [N:0] c;

  assign c[0] = cin;

  // Ripple chain: bit i consumes the carry produced by bit i-1.
  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[N];
  assign c_msb = c[N-1];

endmodule

// File: rtl/ripple_carry_adder_pipelined.sv
// Pipelined WIDTH-bit ripple-carry adder: one CHUNK-bit ripple per stage,
// carry registered between stages, operands skewed forward and finished
// sum chunks carried along so a whole result leaves in one beat.
//
// Handshake: an operand set transfers on a clock edge where
// in_valid && in_ready; a result transfers on an edge where
// out_valid && out_ready. The whole pipeline moves as one
// (advance = !out_valid || out_ready, in_ready = advance); bubbles are
// carried, not squeezed out, and outputs hold stable while stalled.
module ripple_carry_adder_pipelined
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  `ADDER_PARAM_CHECK(WIDTH, STAGES)

  logic              advance;

  // Registered state after each stage.
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] carry_r;
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic [WIDTH-1:0]  acc_r [STAGES];
  logic              ovf_r;

  // Next-state values produced by each stage's combinational logic.
  logic [STAGES-1:0] nxt_v;
  logic [STAGES-1:0] nxt_c;
  logic [WIDTH-1:0]  nxt_a   [STAGES];
  logic [WIDTH-1:0]  nxt_b   [STAGES];
  logic [WIDTH-1:0]  nxt_acc [STAGES];
  logic              nxt_ovf;
  logic              last_cmsb;

  assign advance  = !vld_r[STAGES-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_acc;
    logic             src_c;
    logic             src_v;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic [WIDTH-1:0] stage_acc;

    if (k == 0) begin : g_head
      assign src_a   = a;
      assign src_b   = b;
      assign src_acc = '0;
      assign src_c   = cin;
      assign src_v   = in_valid;
    end else begin : g_body
      assign src_a   = a_r[k-1];
      assign src_b   = b_r[k-1];
      assign src_acc = acc_r[k-1];
      assign src_c   = carry_r[k-1];
      assign src_v   = vld_r[k-1];
    end

    rca_chunk #(.N(CHUNK)) u_chunk (
      .a     (src_a[k*CHUNK +: CHUNK]),
      .b     (src_b[k*CHUNK +: CHUNK]),
      .cin   (src_c),
      .sum   (chunk_sum),
      .cout  (chunk_cout),
      .c_msb (chunk_cmsb)
    );

    // Drop this stage's chunk into the partially built sum.
    always_comb begin
      stage_acc = src_acc;
      stage_acc[k*CHUNK +: CHUNK] = chunk_sum;
    end

    assign nxt_a[k]   = src_a;
    assign nxt_b[k]   = src_b;
    assign nxt_acc[k] = stage_acc;
    assign nxt_c[k]   = chunk_cout;
    assign nxt_v[k]   = src_v;

    if (k == STAGES - 1) begin : g_tail
      assign last_cmsb = chunk_cmsb;
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign nxt_ovf = last_cmsb ^ nxt_c[STAGES-1];

  // Pipeline registers: cleared on reset, shifted together on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r   <= '0;
      carry_r <= '0;
      ovf_r   <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_r[i]   <= '0;
        b_r[i]   <= '0;
        acc_r[i] <= '0;
      end
    end else if (advance) begin
      vld_r   <= nxt_v;
      carry_r <= nxt_c;
      ovf_r   <= nxt_ovf;
      for (int i = 0; i < STAGES; i++) begin
        a_r[i]   <= nxt_a[i];
        b_r[i]   <= nxt_b[i];
        acc_r[i] <= nxt_acc[i];
      end
    end
  end

  assign out_valid = vld_r[STAGES-1];
  assign sum       = acc_r[STAGES-1];
  assign cout      = carry_r[STAGES-1];
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_ripple_carry_adder_pipelined.sv
// Bench for ripple_carry_adder_pipelined (WIDTH=32, STAGES=4).
module tb_ripple_carry_adder_pipelined;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int EW = W + 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  ripple_carry_adder_pipelined #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            lat_exact = 1'b1;
  bit            held_valid = 1'b0;
  logic [EW-1:0] held;
  bit            rand_done = 1'b0;

  // Reference: plain wide arithmetic plus the sign rule for overflow.
  function automatic logic [EW-1:0] ref_model(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic         c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         o;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    o    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {s, full[W], o};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Record every accepted operand set with its expected result.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(ref_model(a, b, cin));
      acc_q.push_back(cyc);
    end
  end

  // Monitor: compare results as they transfer, and watch stalls.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (out_ready) begin
        held_valid = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h with nothing outstanding", {sum, cout, overflow});
        end else begin
          logic [EW-1:0] e;
          int            t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          checks--;
          check("result", {sum, cout, overflow}, e);
          if (lat_exact) check("latency", EW'(cyc - t), EW'(S));
        end
      end else begin
        check("stall_in_ready", EW'(in_ready), EW'(0));
        if (held_valid) check("stall_hold", {sum, cout, overflow}, held);
        held = {sum, cout, overflow};
        held_valid = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c);
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, need 0", exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", EW'(out_valid), EW'(0));
    check("reset_outputs", {sum, cout, overflow}, '0);
    exp_q.delete();
    acc_q.delete();
    held_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", EW'(in_ready), EW'(1));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    #12;
    check("por_out_valid", EW'(out_valid), EW'(0));
    check("por_outputs", {sum, cout, overflow}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("por_in_ready", EW'(in_ready), EW'(1));

    // Directed corner cases with exact latency.
    lat_exact = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    send(32'h0000_FFFF, 32'h0000_FFFF, 1'b1);
    drain();

    // Known sums written out directly as a sanity anchor for the model.
    check("model_anchor_wrap", ref_model(32'hFFFF_FFFF, 32'h1, 1'b0), {32'h0, 1'b1, 1'b0});

    // Back-to-back stream a=b=i.
    for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0);
    drain();

    // Fill, then stall the consumer.
    lat_exact = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)));
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Random traffic with random gaps and random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operations in flight: nothing may emerge afterwards.
    lat_exact = 1'b1;
    out_ready = 1'b1;
    send(32'h1111_1111, 32'h2222_2222, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b1);
    send(32'h5555_5555, 32'h6666_6666, 1'b0);
    pulse_reset();
    repeat (6) begin
      @(negedge clk);
      check("post_reset_idle", EW'(out_valid), EW'(0));
    end
    @(posedge clk);
    #1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    drain();

    check("queue_empty", EW'(exp_q.size()), EW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
